// File: rtl/serial_to_parallel.sv
// Target-side serial bridge: deserializes request frames, replays them on a
// parallel target port and serializes a response frame back for reads.
module serial_to_parallel #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sdata_i,
    input  logic                  sclk_i,
    input  logic                  svalid_i,
    output logic                  sdata_o,
    output logic                  sclk_o,
    output logic                  svalid_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  err_i,
    output logic                  frame_err_o
);

    localparam int FL    = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(FL + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        BUS        = 2'd1,
        RESP_LOAD  = 2'd2,
        RESP_SHIFT = 2'd3
    } state_t;

    // Parity bit that makes the total count of ones (payload + parity) even.
    function automatic logic even_parity(input logic [FL-2:0] bits);
        return ^bits;
    endfunction

    function automatic logic parity_ok(input logic [FL-1:0] frame);
        return ~(^frame);
    endfunction

    state_t                  r_state;
    state_t                  w_next;

    logic [1:0]              r_sdata_sync;
    logic [2:0]              r_sclk_sync;
    logic [1:0]              r_svalid_sync;

    logic [FL-2:0]           r_rx_shift;
    logic [CNT_W-1:0]        r_rx_cnt;

    logic                    r_valid;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_we;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic                    r_frame_err;

    logic                    r_resp_cmd;
    logic [ADDR_WIDTH-1:0]   r_resp_addr;
    logic [DATA_WIDTH-1:0]   r_resp_data;

    logic [FL-1:0]           r_tx_shift;
    logic [CNT_W-1:0]        r_tx_cnt;
    logic [DIV_W-1:0]        r_div_cnt;
    logic                    r_sclk;
    logic                    r_svalid;

    logic                    w_capture;
    logic                    w_frame_done;
    logic [FL-1:0]           w_rx_frame;
    logic                    w_rx_cmd;
    logic [ADDR_WIDTH-1:0]   w_rx_addr;
    logic [DATA_WIDTH-1:0]   w_rx_data;
    logic                    w_rx_par_ok;
    logic                    w_bus_done;
    logic                    w_bus_tmo;
    logic                    w_tx_bit_end;
    logic                    w_tx_last;

    // Two-flop synchronizers; sclk carries one extra stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sdata_sync  <= 2'b00;
            r_sclk_sync   <= 3'b000;
            r_svalid_sync <= 2'b00;
        end else begin
            r_sdata_sync  <= {r_sdata_sync[0], sdata_i};
            r_sclk_sync   <= {r_sclk_sync[1:0], sclk_i};
            r_svalid_sync <= {r_svalid_sync[0], svalid_i};
        end
    end

    assign w_capture    = r_sclk_sync[1] & ~r_sclk_sync[2] & r_svalid_sync[1];
    assign w_frame_done = w_capture & (r_rx_cnt == BIT_LAST);
    assign w_rx_frame   = {r_rx_shift, r_sdata_sync[1]};
    assign w_rx_cmd     = w_rx_frame[FL-1];
    assign w_rx_addr    = w_rx_frame[FL-2 -: ADDR_WIDTH];
    assign w_rx_data    = w_rx_frame[DATA_WIDTH:1];
    assign w_rx_par_ok  = parity_ok(w_rx_frame);

    // Receive shifter keeps running in every state so framing never slips.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
        end else if (!r_svalid_sync[1]) begin
            r_rx_cnt   <= '0;
        end else if (w_capture) begin
            r_rx_shift <= {r_rx_shift[FL-3:0], r_sdata_sync[1]};
            r_rx_cnt   <= (r_rx_cnt == BIT_LAST) ? '0 : r_rx_cnt + CNT_W'(1);
        end
    end

    assign w_bus_done   = (r_state == BUS) & ready_i;
    assign w_bus_tmo    = (r_state == BUS) & ~ready_i & (r_tmo_cnt == TMO_LAST);
    assign w_tx_bit_end = (r_state == RESP_SHIFT) & r_sclk & (r_div_cnt == DIV_LAST);
    assign w_tx_last    = w_tx_bit_end & (r_tx_cnt == BIT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (w_frame_done) begin
                    if (w_rx_par_ok) begin
                        w_next = BUS;
                    end else if (w_rx_cmd == CMD_READ) begin
                        w_next = RESP_LOAD;
                    end else begin
                        w_next = RX_IDLE;
                    end
                end else begin
                    w_next = RX_IDLE;
                end
            end
            BUS: begin
                if (w_bus_done || w_bus_tmo) begin
                    if (r_we) begin
                        w_next = RX_IDLE;
                    end else begin
                        w_next = RESP_LOAD;
                    end
                end else begin
                    w_next = BUS;
                end
            end
            RESP_LOAD: begin
                w_next = RESP_SHIFT;
            end
            RESP_SHIFT: begin
                if (w_tx_last) begin
                    w_next = RX_IDLE;
                end else begin
                    w_next = RESP_SHIFT;
                end
            end
            default: begin
                w_next = RX_IDLE;
            end
        endcase
    end

    // Downstream transaction, timeout and response-field capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_tmo_cnt   <= '0;
            r_resp_cmd  <= 1'b0;
            r_resp_addr <= '0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_frame_done && w_rx_par_ok) begin
                        r_valid   <= 1'b1;
                        r_addr    <= w_rx_addr;
                        r_wdata   <= w_rx_data;
                        r_we      <= (w_rx_cmd == CMD_WRITE);
                        r_tmo_cnt <= '0;
                    end else if (w_frame_done && (w_rx_cmd == CMD_READ)) begin
                        r_resp_cmd  <= CMD_WRITE;
                        r_resp_addr <= w_rx_addr;
                        r_resp_data <= '0;
                    end
                end
                BUS: begin
                    if (w_bus_done) begin
                        r_valid     <= 1'b0;
                        r_resp_cmd  <= err_i ? CMD_WRITE : CMD_READ;
                        r_resp_addr <= r_addr;
                        r_resp_data <= rdata_i;
                    end else if (w_bus_tmo) begin
                        r_valid     <= 1'b0;
                        r_resp_cmd  <= CMD_WRITE;
                        r_resp_addr <= r_addr;
                        r_resp_data <= '0;
                    end else begin
                        r_tmo_cnt   <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Any frame that is bad or arrives while busy is reported and dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_done & ((r_state != RX_IDLE) | ~w_rx_par_ok);
        end
    end

    // Response serializer: data changes at the end of each high phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_div_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_svalid   <= 1'b0;
        end else begin
            case (r_state)
                RESP_LOAD: begin
                    r_tx_shift <= {r_resp_cmd, r_resp_addr, r_resp_data,
                                   even_parity({r_resp_cmd, r_resp_addr, r_resp_data})};
                    r_tx_cnt   <= '0;
                    r_div_cnt  <= '0;
                    r_sclk     <= 1'b0;
                    r_svalid   <= 1'b1;
                end
                RESP_SHIFT: begin
                    if (r_div_cnt != DIV_LAST) begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else if (!r_sclk) begin
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b1;
                    end else begin
                        r_div_cnt  <= '0;
                        r_sclk     <= 1'b0;
                        r_tx_shift <= {r_tx_shift[FL-2:0], 1'b0};
                        r_tx_cnt   <= r_tx_cnt + CNT_W'(1);
                        r_svalid   <= ~w_tx_last;
                    end
                end
                default: begin
                    r_sclk   <= 1'b0;
                    r_svalid <= 1'b0;
                end
            endcase
        end
    end

    assign sdata_o     = r_tx_shift[FL-1];
    assign sclk_o      = r_sclk;
    assign svalid_o    = r_svalid;
    assign valid_o     = r_valid;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign we_o        = r_we;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: serial request driver, downstream
// responder, response-frame decoder and hand-computed expectations.
module tb_serial_to_parallel;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int CD = 2;
    localparam int TO = 64;
    localparam int FL = AW + DW + 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          sdata_i, sclk_i, svalid_i;
    logic          sdata_o, sclk_o, svalid_o;
    logic          valid_o, we_o, frame_err_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          ready_i = 1'b0;
    logic [DW-1:0] rdata_i = 8'h00;
    logic          err_i   = 1'b0;

    serial_to_parallel #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(CD), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sdata_i(sdata_i), .sclk_i(sclk_i), .svalid_i(svalid_i),
        .sdata_o(sdata_o), .sclk_o(sclk_o), .svalid_o(svalid_o),
        .valid_o(valid_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o),
        .ready_i(ready_i), .rdata_i(rdata_i), .err_i(err_i),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Downstream responder: ready_i after cfg_delay cycles of valid_o.
    int          cfg_delay = 0;
    logic [DW-1:0] cfg_rdata = 8'h00;
    logic        cfg_err = 1'b0;
    int          bus_wait = 0;
    always @(negedge clk_i) begin
        if (valid_o) begin
            if (bus_wait == cfg_delay) begin
                ready_i = 1'b1; rdata_i = cfg_rdata; err_i = cfg_err;
            end else begin
                ready_i = 1'b0; rdata_i = 8'h00; err_i = 1'b0;
            end
            bus_wait++;
        end else begin
            bus_wait = 0; ready_i = 1'b0; rdata_i = 8'h00; err_i = 1'b0;
        end
    end

    // Downstream and frame-error monitor.
    int            valid_rises = 0, valid_cnt = 0, valid_len = 0, stable_err = 0, ferr_count = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic          cap_we = 1'b0, prev_valid = 1'b0;
    always @(negedge clk_i) begin
        if (frame_err_o) ferr_count++;
        if (valid_o) begin
            if (!prev_valid) begin
                valid_rises++; valid_cnt = 0;
                cap_addr = addr_o; cap_wdata = wdata_o; cap_we = we_o;
            end else if (addr_o !== cap_addr || wdata_o !== cap_wdata || we_o !== cap_we) begin
                stable_err++;
            end
            valid_cnt++;
        end else if (prev_valid) begin
            valid_len = valid_cnt;
        end
        prev_valid = valid_o;
    end

    // Response deserializer.
    logic [FL-1:0] rsp_shift = '0, rsp_frame = '0;
    int            rsp_bits = 0, rsp_nbits = 0, rsp_cyc = 0, rsp_len = 0, rsp_count = 0;
    logic          prev_sclk = 1'b0, prev_svalid = 1'b0;
    always @(negedge clk_i) begin
        if (svalid_o) begin
            if (!prev_svalid) begin
                rsp_shift = '0; rsp_bits = 0; rsp_cyc = 0;
            end
            rsp_cyc++;
            if (sclk_o && !prev_sclk) begin
                rsp_shift = {rsp_shift[FL-2:0], sdata_o};
                rsp_bits++;
            end
        end else if (prev_svalid) begin
            rsp_frame = rsp_shift; rsp_len = rsp_cyc; rsp_nbits = rsp_bits; rsp_count++;
        end
        prev_sclk   = sclk_o;
        prev_svalid = svalid_o;
    end

    task automatic send_frame(input logic [FL-1:0] f, input int half);
        @(negedge clk_i);
        svalid_i = 1'b1;
        for (int i = FL - 1; i >= 0; i--) begin
            sdata_i = f[i]; sclk_i = 1'b0;
            repeat (half) @(negedge clk_i);
            sclk_i = 1'b1;
            repeat (half) @(negedge clk_i);
        end
        sclk_i = 1'b0;
        repeat (half) @(negedge clk_i);
        svalid_i = 1'b0; sdata_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_rsp(input int base, input string tag);
        int i = 0;
        while (rsp_count == base && i < 600) begin
            @(negedge clk_i);
            i++;
        end
        check_val(tag, 32'(rsp_count > base), 32'd1);
    endtask

    task automatic check_rsp(input string tag, input logic cmd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic par);
        check_val({tag, "_cmd"},  32'(rsp_frame[FL-1]), 32'(cmd));
        check_val({tag, "_addr"}, 32'(rsp_frame[FL-2 -: AW]), 32'(a));
        check_val({tag, "_data"}, 32'(rsp_frame[DW:1]), 32'(d));
        check_val({tag, "_par"},  32'(rsp_frame[0]), 32'(par));
        check_val({tag, "_even"}, 32'(^rsp_frame), 32'd0);
        check_val({tag, "_bits"}, 32'(rsp_nbits), 32'(FL));
        check_val({tag, "_len"},  32'(rsp_len), 32'(FL * 2 * CD));
    endtask

    int base_r, base_v, base_f;

    task automatic snap();
        base_r = rsp_count; base_v = valid_rises; base_f = ferr_count;
    endtask

    initial begin
        rst_ni = 1'b0; sdata_i = 1'b0; sclk_i = 1'b0; svalid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("rst_valid",  32'(valid_o), 32'd0);
        check_val("rst_sclk",   32'(sclk_o), 32'd0);
        check_val("rst_svalid", 32'(svalid_o), 32'd0);
        check_val("rst_sdata",  32'(sdata_o), 32'd0);
        check_val("rst_ferr",   32'(frame_err_o), 32'd0);
        check_val("rst_addr",   32'(addr_o), 32'd0);
        check_val("rst_wdata",  32'(wdata_o), 32'd0);
        check_val("rst_we",     32'(we_o), 32'd0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        // Posted write, ready 3 cycles after valid.
        snap(); cfg_delay = 3;
        send_frame({1'b1, 16'h1234, 8'hA5, 1'b0}, 3);
        repeat (20) @(negedge clk_i);
        check_val("wr_rises",  32'(valid_rises - base_v), 32'd1);
        check_val("wr_we",     32'(cap_we), 32'd1);
        check_val("wr_addr",   32'(cap_addr), 32'h1234);
        check_val("wr_wdata",  32'(cap_wdata), 32'hA5);
        check_val("wr_len",    32'(valid_len), 32'd4);
        check_val("wr_vlow",   32'(valid_o), 32'd0);
        check_val("wr_no_rsp", 32'(rsp_count - base_r), 32'd0);
        check_val("wr_no_err", 32'(ferr_count - base_f), 32'd0);

        // Good read.
        snap(); cfg_delay = 1; cfg_rdata = 8'h3C; cfg_err = 1'b0;
        send_frame({1'b0, 16'h0010, 8'h00, 1'b1}, 3);
        wait_rsp(base_r, "rd_seen");
        check_val("rd_rises", 32'(valid_rises - base_v), 32'd1);
        check_val("rd_we",    32'(cap_we), 32'd0);
        check_val("rd_addr",  32'(cap_addr), 32'h0010);
        check_rsp("rd", 1'b0, 16'h0010, 8'h3C, 1'b1);

        // Read with downstream error.
        snap(); cfg_delay = 0; cfg_rdata = 8'hFF; cfg_err = 1'b1;
        send_frame({1'b0, 16'h0020, 8'h00, 1'b1}, 3);
        wait_rsp(base_r, "rderr_seen");
        check_rsp("rderr", 1'b1, 16'h0020, 8'hFF, 1'b0);
        cfg_err = 1'b0;

        // Read with a flipped data bit.
        snap();
        send_frame({1'b0, 16'h0030, 8'h01, 1'b0}, 3);
        wait_rsp(base_r, "par_seen");
        check_val("par_ferr",  32'(ferr_count - base_f), 32'd1);
        check_val("par_novld", 32'(valid_rises - base_v), 32'd0);
        check_rsp("par", 1'b1, 16'h0030, 8'h00, 1'b1);

        // Read that never gets ready_i.
        snap(); cfg_delay = 1000;
        send_frame({1'b0, 16'h0040, 8'h00, 1'b1}, 3);
        wait_rsp(base_r, "tmo_seen");
        check_val("tmo_len", 32'(valid_len), 32'(TO));
        check_rsp("tmo", 1'b1, 16'h0040, 8'h00, 1'b0);

        // Second write arrives while the first is still on the bus.
        snap(); cfg_delay = 1000;
        send_frame({1'b1, 16'h0100, 8'h11, 1'b0}, 1);
        send_frame({1'b1, 16'h0200, 8'h22, 1'b0}, 1);
        repeat (80) @(negedge clk_i);
        check_val("busy_rises",  32'(valid_rises - base_v), 32'd1);
        check_val("busy_addr",   32'(cap_addr), 32'h0100);
        check_val("busy_wdata",  32'(cap_wdata), 32'h11);
        check_val("busy_ferr",   32'(ferr_count - base_f), 32'd1);
        check_val("busy_len",    32'(valid_len), 32'(TO));
        check_val("busy_no_rsp", 32'(rsp_count - base_r), 32'd0);
        check_val("stable",      32'(stable_err), 32'd0);

        // Asynchronous reset in the middle of a response.
        cfg_delay = 0; cfg_rdata = 8'h5A;
        send_frame({1'b0, 16'h0050, 8'h00, 1'b0}, 3);
        begin
            int i = 0;
            while (!(svalid_o && sclk_o) && i < 600) begin
                @(negedge clk_i);
                i++;
            end
        end
        check_val("ar_in_shift", 32'(svalid_o && sclk_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_val("ar_sclk",   32'(sclk_o), 32'd0);
        check_val("ar_svalid", 32'(svalid_o), 32'd0);
        check_val("ar_valid",  32'(valid_o), 32'd0);
        check_val("ar_sdata",  32'(sdata_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Target-side bridge at the far end of the serial link from the initiator bridge.
- Deserializes request frames and replays each one as a parallel bus transaction on a downstream target port.
- For reads, serializes a response frame back to the initiator carrying the read data and the error status.
- Writes are posted: no response frame is returned.

Parameters:
- ADDR_WIDTH, 16, address field width (equals bus_pkg ADDR_WIDTH).
- DATA_WIDTH, 8, data field width (equals bus_pkg DATA_WIDTH).
- CLK_DIV, 2, clk_i cycles per sclk_o half-period (>=1).
- TIMEOUT, 64, maximum clk_i cycles valid_o waits for ready_i before the transaction is abandoned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- sdata_i  in  1  request serial data
- sclk_i  in  1  request serial clock; data sampled on its rising edge
- svalid_i  in  1  request frame envelope; high for the whole frame
- sdata_o  out  1  response serial data
- sclk_o  out  1  response serial clock
- svalid_o  out  1  response frame envelope
- valid_o  out  1  downstream request valid
- addr_o  out  ADDR_WIDTH  downstream address
- wdata_o  out  DATA_WIDTH  downstream write data
- we_o  out  1  downstream write enable
- ready_i  in  1  downstream completion
- rdata_i  in  DATA_WIDTH  downstream read data, valid with ready_i
- err_i  in  1  downstream error, valid with ready_i
- frame_err_o  out  1  one-cycle pulse: received parity error or dropped frame

Behaviour:
- Frame format, MSB first, FL = ADDR_WIDTH+DATA_WIDTH+2 bits: cmd (CMD_WRITE=1, CMD_READ=0), addr, data, parity. The parity bit makes the total number of 1s across the whole frame even.
- Input synchronization: sdata_i, sclk_i and svalid_i each pass through a 2-flop synchronizer. A bit is captured when the synchronized sclk shows a rising edge while synchronized svalid is high.
- Receive counter: svalid low clears the bit counter. A partial frame followed by svalid falling is discarded silently. A frame completes on capture of bit FL.
- Reset values: all outputs 0 (sclk_o low, svalid_o low, valid_o low, addr_o/wdata_o 0, frame_err_o 0). FSM in RX_IDLE.
- FSM states: RX_IDLE, BUS, RESP_LOAD, RESP_SHIFT.
- RX_IDLE, frame completes:
  - parity bad and cmd=WRITE: pulse frame_err_o, stay in RX_IDLE.
  - parity bad and cmd=READ: pulse frame_err_o, go to RESP_LOAD with response cmd=CMD_WRITE (error) and data=0.
  - parity good: on the next cycle drive valid_o=1 with addr_o, wdata_o and we_o=(cmd==CMD_WRITE), go to BUS.
- BUS:
  - valid_o and payload are held stable until ready_i is sampled high.
  - ready_i high in the same cycle valid_o rises counts as completion.
  - On completion drop valid_o next cycle. Write: go to RX_IDLE. Read: latch rdata_i, err_i, go to RESP_LOAD.
  - Timeout counter starts at 0 when valid_o rises. After TIMEOUT cycles without ready_i: drop valid_o. Write: go to RX_IDLE. Read: error response, data=0.
- Response frame: cmd = CMD_READ on success, CMD_WRITE on error. addr = echo of the request addr. data = latched rdata. parity per the frame format.
- RESP_LOAD: load the shift register, assert svalid_o, go to RESP_SHIFT.
- RESP_SHIFT, each bit:
  - sdata_o is set while sclk_o is low, then held for CLK_DIV cycles low followed by CLK_DIV cycles high.
  - sclk_o returns low after the last bit. svalid_o deasserts on the cycle after the final high phase, then go to RX_IDLE.
  - Frame duration = FL*2*CLK_DIV cycles of svalid_o high.
- Frames that complete while not in RX_IDLE are dropped with a frame_err_o pulse. The receiver keeps shifting, so the next frame after a gap is still aligned.
- Async reset mid-operation: all outputs return to reset values immediately. Any in-flight bus transaction or response is discarded.

Test Plan:
- Write frame addr=0x1234, data=0xA5, good parity -> one bus cycle with valid_o=1, we_o=1, addr_o=0x1234, wdata_o=0xA5. Downstream asserts ready_i 3 cycles later -> valid_o low next cycle. svalid_o never rises.
- Read frame addr=0x0010, downstream ready_i with rdata_i=0x3C, err_i=0 -> response frame cmd=0, addr=0x0010, data=0x3C, even parity. svalid_o high for exactly 26*2*CLK_DIV cycles (FL=26 at default widths); the bench's deserializer decodes the frame with no parity error.
- Read with err_i=1 and rdata_i=0xFF -> response cmd=1 (CMD_WRITE), data=0xFF.
- Read frame with one flipped data bit -> frame_err_o pulses once, no valid_o, response cmd=1, data=0x00.
- Read with ready_i tied low -> valid_o held exactly TIMEOUT=64 cycles then dropped; error response sent.
- Second write frame sent while the FSM is in BUS -> frame_err_o pulses, only the first transaction appears downstream. Reset asserted during RESP_SHIFT -> sclk_o, svalid_o and valid_o go low asynchronously.
